// File: rtl/positron_argmax.sv
// -----------------------------------------------------------------------------
// positron_argmax
//
// Streams the posit scores of one classification word (one image) and reports
// the index and value of the largest score. NaR never wins against a real
// value. If every score is NaR, class 0 is reported together with NaR.
//
// Handshake (both sides): a transfer happens on a rising edge where the
// sender's rts and the receiver's rtr are both 1. The sender holds its data
// stable until that edge. rtr_o is 1 only in ACCUM. rts_o is 1 only in OUT.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rts_i, eow_i, posit_i upstream beat: valid, end-of-word, score
//   rtr_o                 ready towards upstream
//   rtr_i                 downstream ready
//   rts_o                 result valid
//   class_o, max_posit_o  winning class index and score
//   img_cnt_o             wrapping index of the image this result belongs to
//   nar_o                 every score of the image was NaR
//   len_err_o             eow_i did not coincide with the last class index
// -----------------------------------------------------------------------------
module positron_argmax #(
  parameter int POSIT_WIDTH   = 8,
  parameter int POSIT_ES      = 0,
  parameter int NB_CLASSES    = 10,
  parameter int IMG_CNT_WIDTH = 16,
  localparam int CLASS_WIDTH  = (NB_CLASSES > 1) ? $clog2(NB_CLASSES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rts_i,
  input  logic                     eow_i,
  input  logic [POSIT_WIDTH-1:0]   posit_i,
  output logic                     rtr_o,
  input  logic                     rtr_i,
  output logic                     rts_o,
  output logic [CLASS_WIDTH-1:0]   class_o,
  output logic [POSIT_WIDTH-1:0]   max_posit_o,
  output logic [IMG_CNT_WIDTH-1:0] img_cnt_o,
  output logic                     nar_o,
  output logic                     len_err_o
);

  // Ordering uses the raw bit pattern, so the exponent size has no effect
  // on the datapath; it is only range-checked here.
  if (POSIT_WIDTH < 3 || POSIT_ES < 0 || NB_CLASSES < 1) begin : g_bad_params
    $error("positron_argmax: illegal parameter combination");
  end

  localparam logic [POSIT_WIDTH-1:0] NAR      = {1'b1, {(POSIT_WIDTH-1){1'b0}}};
  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NB_CLASSES - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     armed_q;    // low only until the first edge after reset
  logic [CLASS_WIDTH-1:0]   idx_q;
  logic [IMG_CNT_WIDTH-1:0] img_cnt_q;
  logic [POSIT_WIDTH-1:0]   max_q;
  logic [CLASS_WIDTH-1:0]   class_q;
  logic                     nar_q;
  logic                     len_err_q;

  logic accept;
  logic at_last_idx;
  logic last_beat;
  logic is_nar;
  logic take;
  logic done;

  assign rtr_o       = armed_q && (state_q == ACCUM);
  assign rts_o       = (state_q == OUT);
  assign accept      = rts_i && rtr_o;
  assign done        = rts_o && rtr_i;
  assign at_last_idx = (idx_q == LAST_IDX);
  assign last_beat   = eow_i || at_last_idx;
  assign is_nar      = (posit_i == NAR);

  // NaR is the most negative two's-complement pattern, so a strict signed
  // compare already keeps it from beating any real value, and a NaR loaded
  // on the first beat is displaced by the first real value seen. Strict '>'
  // keeps the lowest index on ties.
  assign take = (idx_q == '0) || ($signed(posit_i) > $signed(max_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_beat) state_d = OUT;
      OUT:     if (rtr_i)               state_d = ACCUM;
      default:                          state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      idx_q     <= '0;
      img_cnt_q <= '0;
      max_q     <= '0;
      class_q   <= '0;
      nar_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        if (take) begin
          max_q   <= posit_i;
          class_q <= idx_q;
        end
        nar_q <= (idx_q == '0) ? is_nar : (nar_q && is_nar);
        if (last_beat) begin
          idx_q     <= '0;
          len_err_q <= (eow_i != at_last_idx);
        end else begin
          idx_q <= idx_q + CLASS_WIDTH'(1);
        end
      end else if (done) begin
        max_q     <= '0;
        class_q   <= '0;
        nar_q     <= 1'b0;
        len_err_q <= 1'b0;
        img_cnt_q <= img_cnt_q + IMG_CNT_WIDTH'(1);
      end
    end
  end

  assign class_o     = class_q;
  assign max_posit_o = max_q;
  assign img_cnt_o   = img_cnt_q;
  assign nar_o       = nar_q;
  assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_positron_argmax.sv
module tb_positron_argmax;

  localparam int PW = 4;
  localparam int NB = 10;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int EW = IW + CW + PW + 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rts_i   = 1'b0;
  logic          eow_i   = 1'b0;
  logic [PW-1:0] posit_i = '0;
  logic          rtr_i   = 1'b0;
  logic          rtr_o;
  logic          rts_o;
  logic [CW-1:0] class_o;
  logic [PW-1:0] max_posit_o;
  logic [IW-1:0] img_cnt_o;
  logic          nar_o;
  logic          len_err_o;

  positron_argmax #(
    .POSIT_WIDTH(PW), .POSIT_ES(0), .NB_CLASSES(NB), .IMG_CNT_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .eow_i(eow_i), .posit_i(posit_i),
    .rtr_o(rtr_o), .rtr_i(rtr_i), .rts_o(rts_o), .class_o(class_o),
    .max_posit_o(max_posit_o), .img_cnt_o(img_cnt_o), .nar_o(nar_o),
    .len_err_o(len_err_o)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] img[NB];
  logic [IW-1:0] drv_img   = '0;
  bit            rand_gaps = 1'b0;
  int            n_tests   = 0;
  int            n_fail    = 0;
  logic [EW-1:0] got;
  logic [EW-1:0] exp_v;

  assign got = {img_cnt_o, class_o, max_posit_o, nar_o, len_err_o};

  // Reference: NaR is skipped outright; the first strictly larger real value wins.
  function automatic logic [EW-1:0] ref_model(input int n, input bit eow_last,
                                              input logic [IW-1:0] cnt);
    int best;
    int bv;
    int v;
    logic err;
    best = -1;
    bv   = 0;
    err  = (n != NB) || !eow_last;
    for (int i = 0; i < n; i++) begin
      if (img[i] != 4'h8) begin
        v = img[i][PW-1] ? int'(img[i]) - 16 : int'(img[i]);
        if (best < 0 || v > bv) begin
          best = i;
          bv   = v;
        end
      end
    end
    if (best < 0) return {cnt, 4'd0, 4'h8, 1'b1, err};
    return {cnt, CW'(best), img[best], 1'b0, err};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic load_img(input logic [4*NB-1:0] pat);
    for (int i = 0; i < NB; i++) img[i] = pat[4*NB-1-4*i -: 4];
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic drive_beat(input logic [PW-1:0] p, input logic e);
    int t;
    t       = 0;
    rts_i   = 1'b1;
    posit_i = p;
    eow_i   = e;
    while (rtr_o !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (rtr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_timeout rtr_o=%b required 1", rtr_o);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_image(input int n, input bit eow_last);
    exp_q.push_back(ref_model(n, eow_last, drv_img));
    drv_img++;
    for (int i = 0; i < n; i++) begin
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
        rts_i   = 1'b0;
        eow_i   = 1'($urandom_range(0, 1));
        posit_i = PW'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drive_beat(img[i], (i == n - 1) && eow_last);
    end
    rts_i = 1'b0;
    eow_i = 1'b0;
  endtask

  task automatic release_result;
    rts_i = 1'b0;
    rtr_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rtr_i = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    exp_q.delete();
    drv_img = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rtr_o, rts_o, got} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got=%h required 0", {rtr_o, rts_o, got});
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (rtr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rtr_before_edge rtr_o=%b required 0", rtr_o);
    end
    @(negedge clk);
    n_tests++;
    if (rtr_o !== 1'b1 || rts_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rtr_after_edge rtr_o=%b rts_o=%b required 1 0", rtr_o, rts_o);
    end
  endtask

  task automatic test_basic;
    load_img(40'h0142737561);
    send_image(NB, 1'b1);
    n_tests++;
    if (rts_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency rts_o=%b required 1", rts_o);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (got !== exp_v || class_o !== 4'd4 || max_posit_o !== 4'h7) begin
      n_fail++;
      $display("FAIL basic_result got=%h required=%h (class 4 max 7)", got, exp_v);
    end
  endtask

  task automatic test_hold;
    logic [EW-1:0] snap;
    snap  = got;
    rts_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      posit_i = PW'($urandom);
      eow_i   = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if ({rtr_o, rts_o, got} !== {1'b0, 1'b1, snap}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got=%h required=%h", c, {rtr_o, rts_o, got},
                 {1'b0, 1'b1, snap});
      end
    end
    release_result();
    load_img(40'h1111311110);
    send_image(NB, 1'b1);
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rts_o !== 1'b1 || got !== exp_v || img_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_next_image rts_o=%b got=%h required=%h (img_cnt 1)", rts_o, got, exp_v);
    end
    release_result();
  endtask

  task automatic test_negative;
    load_img(40'h9F8CA8BDE9);
    send_image(NB, 1'b1);
    exp_v = exp_q.pop_front();
    n_tests++;
    if (got !== exp_v || class_o !== 4'd1 || max_posit_o !== 4'hF || nar_o !== 1'b0) begin
      n_fail++;
      $display("FAIL negative_result got=%h required=%h", got, exp_v);
    end
    release_result();
    load_img(40'h8888888888);
    send_image(NB, 1'b1);
    exp_v = exp_q.pop_front();
    n_tests++;
    if (got !== exp_v || nar_o !== 1'b1 || class_o !== 4'd0 || max_posit_o !== 4'h8) begin
      n_fail++;
      $display("FAIL all_nar_result got=%h required=%h", got, exp_v);
    end
    release_result();
  endtask

  task automatic test_len_err;
    load_img(40'h2315647777);
    send_image(6, 1'b1);
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rts_o !== 1'b1 || got !== exp_v || len_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL short_image rts_o=%b got=%h required=%h", rts_o, got, exp_v);
    end
    release_result();
    load_img(40'h3212345632);
    send_image(NB, 1'b0);
    exp_v = exp_q.pop_front();
    n_tests++;
    if (rts_o !== 1'b1 || got !== exp_v || len_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL no_eow_image rts_o=%b got=%h required=%h", rts_o, got, exp_v);
    end
    release_result();
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 5; i++) drive_beat(4'h7, 1'b0);
    rts_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rtr_o, rts_o, got} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_values got=%h required 0", {rtr_o, rts_o, got});
    end
    apply_reset();
    load_img(40'h1213011210);
    send_image(NB, 1'b1);
    exp_v = exp_q.pop_front();
    n_tests++;
    if (got !== exp_v || img_cnt_o !== 4'd0 || class_o !== 4'd3) begin
      n_fail++;
      $display("FAIL after_reset_image got=%h required=%h", got, exp_v);
    end
    release_result();
  endtask

  task automatic test_reset_in_out;
    load_img(40'h5555555555);
    send_image(NB, 1'b1);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rtr_o, rts_o, got} !== '0) begin
      n_fail++;
      $display("FAIL out_reset_values got=%h required 0", {rtr_o, rts_o, got});
    end
    apply_reset();
  endtask

  task automatic test_random;
    int got_cnt;
    int cyc;
    got_cnt   = 0;
    cyc       = 0;
    rand_gaps = 1'b1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          int n;
          bit e;
          n = ($urandom_range(0, 9) < 7) ? NB : int'($urandom_range(1, NB - 1));
          e = (n < NB) ? 1'b1 : 1'($urandom_range(0, 1));
          for (int i = 0; i < NB; i++)
            img[i] = ($urandom_range(0, 4) == 0) ? 4'h8 : PW'($urandom_range(0, 15));
          if ($urandom_range(0, 19) == 0) for (int i = 0; i < NB; i++) img[i] = 4'h8;
          send_image(n, e);
        end
      end
      begin
        while (got_cnt < 300 && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          rtr_i = ($urandom_range(0, 2) != 0);
          if (rts_o === 1'b1 && rtr_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL rand_extra_result got=%h required none", got);
            end else begin
              exp_v = exp_q.pop_front();
              if (got !== exp_v) begin
                n_fail++;
                $display("FAIL rand_image%0d got=%h required=%h", got_cnt, got, exp_v);
              end
            end
            got_cnt++;
          end
        end
      end
    join
    rtr_i = 1'b0;
    n_tests++;
    if (got_cnt != 300 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count results=%0d pending=%0d required 300 0", got_cnt, exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_negative();
    test_len_err();
    test_mid_reset();
    test_reset_in_out();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
